// File: rtl/rob_isu.sv
// rob_isu: credit-gated in-order issue stage that tags each request with the next ROB id.
// Define ROB_ISU_BYPASS_EN to let a request skip the empty FIFO and issue in its accept cycle.
module rob_isu #(
    parameter int ROB_SIZE   = 8,
    parameter int ROB_ID_W   = $clog2(ROB_SIZE),
    parameter int CRDT_W     = $clog2(ROB_SIZE + 1),
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                u_req_valid,
    output logic                u_req_ready,
    input  logic [DATA_W-1:0]   u_req_data,
    output logic                d_isu_valid,
    input  logic                d_isu_ready,
    output logic [ROB_ID_W-1:0] d_isu_rob_id,
    output logic [DATA_W-1:0]   d_isu_data,
    input  logic                u_crdt_rtn,
    output logic [CRDT_W-1:0]   crdt_cnt,
    output logic                idle,
    output logic                crdt_err
);
    localparam int PTR_W = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROB_ID_W-1:0] id_q, id_d;
    logic [CRDT_W-1:0]   crdt_q, crdt_d;
    logic                err_q, err_d;
    logic                fifo_empty, fifo_full, has_crdt, crdt_full, byp, push, pop, issue;

    assign fifo_empty = cnt_q == '0;
    assign fifo_full  = cnt_q == CNT_W'(FIFO_DEPTH);
    assign has_crdt   = crdt_q != '0;
    assign crdt_full  = crdt_q == CRDT_W'(ROB_SIZE);
`ifdef ROB_ISU_BYPASS_EN
    assign byp = fifo_empty & has_crdt;
`else
    assign byp = 1'b0;
`endif
    assign u_req_ready  = !fifo_full;
    assign d_isu_valid  = byp ? u_req_valid : (!fifo_empty & has_crdt);
    assign d_isu_data   = byp ? u_req_data : mem_q[rd_ptr_q];
    assign d_isu_rob_id = id_q;
    assign issue        = d_isu_valid & d_isu_ready;
    // A bypassed request that issues immediately never occupies the FIFO
    assign push         = u_req_valid & u_req_ready & !(byp & issue);
    assign pop          = issue & !byp;
    assign crdt_cnt     = crdt_q;
    assign idle         = fifo_empty & crdt_full;
    assign crdt_err     = err_q;

    always_comb begin
        rd_ptr_d = pop ? ((rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        wr_ptr_d = push ? ((wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        id_d     = issue ? ((id_q == ROB_ID_W'(ROB_SIZE - 1)) ? '0 : id_q + 1'b1) : id_q;
        crdt_d   = (issue & !u_crdt_rtn) ? crdt_q - 1'b1 :
                   (u_crdt_rtn & !issue & !crdt_full) ? crdt_q + 1'b1 : crdt_q;
        err_d    = err_q | (u_crdt_rtn & !issue & crdt_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            crdt_q   <= CRDT_W'(ROB_SIZE);
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            crdt_q   <= crdt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= u_req_data;
    end
endmodule
